// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the load/store memory responder.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESPOND
    } state_t;

    localparam logic [3:0] MASK_BYTE0     = 4'b0001;
    localparam logic [3:0] MASK_BYTE1     = 4'b0010;
    localparam logic [3:0] MASK_BYTE2     = 4'b0100;
    localparam logic [3:0] MASK_BYTE3     = 4'b1000;
    localparam logic [3:0] MASK_HALF_LOW  = 4'b0011;
    localparam logic [3:0] MASK_HALF_HIGH = 4'b1100;
    localparam logic [3:0] MASK_WORD      = 4'b1111;

    // A store mask is only legal when it matches the natural alignment of its offset.
    function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] offset);
        case (mask)
            MASK_BYTE0:     return offset == 2'd0;
            MASK_BYTE1:     return offset == 2'd1;
            MASK_BYTE2:     return offset == 2'd2;
            MASK_BYTE3:     return offset == 2'd3;
            MASK_HALF_LOW:  return offset == 2'd0;
            MASK_HALF_HIGH: return offset == 2'd2;
            MASK_WORD:      return offset == 2'd0;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response channel between the core (master) and the memory responder (slave).
interface data_memory_responder_if;
    logic        request_valid;
    logic        request_ready;
    logic        request_write;
    logic [31:0] request_address;
    logic [31:0] request_write_data;
    logic [3:0]  request_write_mask;
    logic        response_valid;
    logic        response_ready;
    logic [31:0] response_read_data;
    logic        response_error;

    modport master (
        output request_valid, request_write, request_address, request_write_data,
               request_write_mask, response_ready,
        input  request_ready, response_valid, response_read_data, response_error
    );

    modport slave (
        input  request_valid, request_write, request_address, request_write_data,
               request_write_mask, response_ready,
        output request_ready, response_valid, response_read_data, response_error
    );
endinterface

// File: rtl/data_memory_responder_byte_lane_memory.sv
// Word storage built from four independent byte lanes with a registered read port.
module byte_lane_memory #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clk,
    input  logic [ADDRESS_WIDTH-1:0] index,
    input  logic [3:0]               write_enable,
    input  logic [31:0]              write_data,
    input  logic                     read_enable,
    output logic [31:0]              read_data
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] storage [2**ADDRESS_WIDTH];
        logic [7:0] read_q;

        always_ff @(posedge clk) begin
            if (write_enable[g]) begin
                storage[index] <= write_data[8*g +: 8];
            end
            if (read_enable) begin
                read_q <= storage[index];
            end
        end

        assign read_data[8*g +: 8] = read_q;
    end

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder: checks, wait states, storage access, response hold.
module data_memory_responder
    import data_memory_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int WAIT_STATES   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    data_memory_responder_if.slave   bus
);

    state_t                   state;
    state_t                   state_next;
    logic [3:0]               wait_count;
    logic                     cap_write;
    logic                     cap_error;
    logic [ADDRESS_WIDTH-1:0] cap_index;
    logic [31:0]              cap_data;
    logic [3:0]               cap_mask;
    logic                     accept;
    logic                     out_of_range;
    logic                     request_error;
    logic [3:0]               lane_write;
    logic                     read_enable;
    logic [31:0]              memory_data;

    assign bus.request_ready = (state == IDLE);
    assign accept            = bus.request_valid && bus.request_ready;
    assign out_of_range      = (bus.request_address >> (ADDRESS_WIDTH + 2)) != 32'd0;
    assign request_error     = out_of_range ||
                               (bus.request_write &&
                                !mask_legal(bus.request_write_mask, bus.request_address[1:0]));

    assign lane_write  = (state == ACCESS && cap_write && !cap_error) ? cap_mask : 4'b0000;
    assign read_enable = (state == ACCESS) && !cap_write && !cap_error;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (wait_count == 4'd0) state_next = ACCESS;
            ACCESS:  state_next = RESPOND;
            RESPOND: if (bus.response_valid && bus.response_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            wait_count             <= 4'd0;
            cap_write              <= 1'b0;
            cap_error              <= 1'b0;
            cap_index              <= '0;
            cap_data               <= 32'd0;
            cap_mask               <= 4'd0;
            bus.response_valid     <= 1'b0;
            bus.response_read_data <= 32'd0;
            bus.response_error     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap_write  <= bus.request_write;
                cap_error  <= request_error;
                cap_index  <= bus.request_address[ADDRESS_WIDTH+1:2];
                cap_data   <= bus.request_write_data;
                cap_mask   <= bus.request_write_mask;
                wait_count <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
            end else if (state == WAIT && wait_count != 4'd0) begin
                wait_count <= wait_count - 4'd1;
            end
            // The registered read lands on entry to RESPOND; the response is latched one cycle later and held.
            if (state == RESPOND) begin
                if (!bus.response_valid) begin
                    bus.response_valid     <= 1'b1;
                    bus.response_read_data <= (cap_write || cap_error) ? 32'd0 : memory_data;
                    bus.response_error     <= cap_error;
                end else if (bus.response_ready) begin
                    bus.response_valid     <= 1'b0;
                    bus.response_read_data <= 32'd0;
                    bus.response_error     <= 1'b0;
                end
            end
        end
    end

    byte_lane_memory #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_storage (
        .clk          (clk),
        .index        (cap_index),
        .write_enable (lane_write),
        .write_data   (cap_data),
        .read_enable  (read_enable),
        .read_data    (memory_data)
    );

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's load/store memory interface.
- Accepts one request at a time from the core over a valid/ready request channel: byte address, pre-lane-shifted write data, 4-bit write mask and read/write flag.
- Performs a byte-masked write or a full-word read on word-addressed backing storage, after a configurable number of wait states.
- Returns read data or an error flag on a valid/ready response channel. The core does all byte/halfword extraction and sign extension.

Parameters:
- ADDRESS_WIDTH, 16: word-address bits. Depth is 2^ADDRESS_WIDTH 32-bit words; byte address bits [ADDRESS_WIDTH+1:2] index storage.
- WAIT_STATES, 1: extra cycles between accept and storage access (0..15).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- request_valid  in  1  core presents a request
- request_ready  out  1  responder can accept a request
- request_write  in  1  1 = store, 0 = load
- request_address  in  32  byte address
- request_write_data  in  32  lane-aligned store data
- request_write_mask  in  4  byte-lane enables (bit i = byte lane i)
- response_valid  out  1  response available
- response_ready  in  1  core consumes the response
- response_read_data  out  32  full word read; 0 for stores and errors
- response_error  out  1  request rejected (misaligned or out of range)

Behaviour:
- Reset (asynchronous, reset_n low):
  - state = IDLE, wait counter = 0.
  - response_valid = 0, response_read_data = 0, response_error = 0.
  - Captured request registers are cleared. Storage contents are not reset.
- request_ready = (state == IDLE), driven combinationally from state. No request is accepted while a response is outstanding.
- Accept on a rising edge with request_valid && request_ready. Capture address, data, mask, write flag and the error check result.
- Error check (evaluated at accept):
  - Out of range: request_address[31:ADDRESS_WIDTH+2] != 0. Applies to loads and stores.
  - Illegal store mask: any mask other than 0001/0010/0100/1000 at address[1:0] = 00/01/10/11 respectively, 0011 at 00, 1100 at 10, or 1111 at 00. A mask of 0000 is illegal.
  - Loads ignore address[1:0] and the mask.
- States:
  - IDLE -> WAIT on accept when WAIT_STATES > 0; counter loads WAIT_STATES-1.
  - IDLE -> ACCESS on accept when WAIT_STATES == 0.
  - WAIT: counter decrements each cycle; at 0 -> ACCESS.
  - ACCESS (one cycle): a non-error store writes the masked byte lanes; a non-error load issues a synchronous read. -> RESPOND.
  - RESPOND: response_valid = 1. response_read_data and response_error are held stable until response_valid && response_ready. On that handshake edge -> IDLE; response_valid drops and request_ready rises in the following cycle.
- Latency:
  - Accept at edge N gives response_valid high after edge N+2+WAIT_STATES.
  - The minimum round trip is WAIT_STATES+3 cycles including the response handshake cycle.
- Data:
  - Unmasked byte lanes keep their previous contents.
  - Error requests never modify storage and return read_data = 0, error = 1.
  - Store responses return read_data = 0, error = 0.
  - The store is committed before its response, so a following load always observes it.
- response_ready held high while IDLE/WAIT has no effect.
- Request inputs changing after accept have no effect.
- Reset mid-operation:
  - The transaction is abandoned and no response is produced.
  - A store is committed only if the ACCESS edge occurred before reset assertion.

Decomposition:
- Package data_memory_pkg holds:
  - state enum: IDLE, WAIT, ACCESS, RESPOND;
  - legal mask constants: MASK_BYTE0..3, MASK_HALF_LOW, MASK_HALF_HIGH, MASK_WORD.
- Sub-module byte_lane_memory holds the storage: four 8-bit lanes of depth 2^ADDRESS_WIDTH, per-lane write enables, synchronous registered read. The state machine and checks stay in data_memory_responder.

Test Plan:
- Word store/load, WAIT_STATES=1:
  - store 0xDEADBEEF, mask 1111, address 0x100 -> response after 3 edges with error 0, data 0.
  - load 0x100 -> response_read_data 0xDEADBEEF.
- Byte and halfword lanes:
  - over word 0x00000000 at 0x200, store data 0x00AB0000 mask 0100 at 0x202, then data 0x12341234 mask 0011 at 0x200.
  - load 0x200 -> 0x00AB1234.
- Errors:
  - store mask 0011 at 0x201 -> error 1, storage unchanged.
  - load at 0x0004_0000 with ADDRESS_WIDTH=16 -> error 1, data 0.
  - store mask 0000 -> error 1.
- Backpressure:
  - hold response_ready low 5 cycles after a load of 0xCAFEF00D -> response_valid and data stay stable, request_ready stays 0.
  - raise response_ready -> IDLE and request_ready = 1 the next cycle.
- Latency sweep:
  - WAIT_STATES = 0, 1, 4 -> response_valid first high exactly 2, 3, 6 edges after accept.
  - back-to-back requests with request_valid held high are each accepted only when in IDLE.
- Reset mid-store:
  - assert reset_n low during WAIT of a store 0x11111111 to 0x300 (previously 0x22222222) -> outputs zero immediately.
  - after reset, load 0x300 -> 0x22222222.
